// File: rtl/vga_plot_arbiter_if.sv
// Signal bundle between the drawing clients/engines and the VGA plot arbiter.
// Handshake: req[i] is a level held by client i until done[i] pulses; eng_start[i] pulses
// for one cycle and engine i answers by raising eng_waitrequest[i] while busy.
interface vga_plot_arbiter_if #(parameter int N = 3);
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [N-1:0]   eng_start;
  logic [N-1:0]   eng_waitrequest;
  logic [N-1:0]   eng_vga_plot;
  logic [8*N-1:0] eng_vga_x;
  logic [7*N-1:0] eng_vga_y;
  logic [3*N-1:0] eng_vga_colour;
  logic           vga_plot;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;

  modport master (
    output req, eng_waitrequest, eng_vga_plot, eng_vga_x, eng_vga_y, eng_vga_colour,
    input  grant, done, eng_start, vga_plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  req, eng_waitrequest, eng_vga_plot, eng_vga_x, eng_vga_y, eng_vga_colour,
    output grant, done, eng_start, vga_plot, vga_x, vga_y, vga_colour
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single vga_adapter plot port: starts one drawing engine at a time,
// forwards only that engine's plot stream, and pulses done to its client when it finishes.
module vga_plot_arbiter #(
  parameter int N           = 3,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_plot_arbiter_if.slave    bus,
  output logic [2:0]           state_dbg
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // Start pulse to forced done spans ARM_TIMEOUT cycles: ISSUE plus ARM_TIMEOUT-1 ARM cycles.
  localparam logic [7:0] ARM_LAST = (ARM_TIMEOUT > 2) ? 8'(ARM_TIMEOUT - 2) : 8'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [IW-1:0] rr;
  logic [IW-1:0] w;
  logic [IW-1:0] win;
  logic [IW:0]   sum;
  logic          found;
  logic [N-1:0]  eligible;
  logic [N-1:0]  win_oh;
  logic          sel_wr;
  logic [7:0]    arm_cnt;

  assign eligible  = bus.req & ~bus.eng_waitrequest;
  assign state_dbg = state;

  // Scan from the rr pointer with wrap; busy engines are not eligible.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (!found && eligible[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // Granted engine's busy flag and VGA fields; forwarded only while it owns the port.
  always_comb begin
    sel_wr         = 1'b0;
    bus.vga_plot   = 1'b0;
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    for (int i = 0; i < N; i++) begin
      if (w == IW'(i)) begin
        sel_wr = bus.eng_waitrequest[i];
        if (state == ARM || state == BUSY) begin
          bus.vga_plot   = bus.eng_vga_plot[i];
          bus.vga_x      = bus.eng_vga_x[8*i +: 8];
          bus.vga_y      = bus.eng_vga_y[7*i +: 7];
          bus.vga_colour = bus.eng_vga_colour[3*i +: 3];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.grant     <= '0;
      bus.done      <= '0;
      bus.eng_start <= '0;
      rr            <= '0;
      w             <= '0;
      arm_cnt       <= '0;
    end else begin
      bus.done      <= '0;
      bus.eng_start <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            w             <= win;
            bus.grant     <= win_oh;
            bus.eng_start <= win_oh;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          arm_cnt <= '0;
          state   <= ARM;
        end
        ARM: begin
          if (sel_wr) begin
            state <= BUSY;
          end else if (arm_cnt >= ARM_LAST) begin
            // Engine never went busy: it finished within the start cycle.
            bus.done <= bus.grant;
            state    <= DONE;
          end else begin
            arm_cnt <= arm_cnt + 8'd1;
          end
        end
        BUSY: begin
          if (!sel_wr) begin
            bus.done <= bus.grant;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.grant <= '0;
          rr        <= (w == IW'(N-1)) ? '0 : w + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
